mem_port_arb: RTL and testbench
===============================

MEM_PORT_ARB -- requirements
Module: mem_port_arb

Interface
REQ-001 SHALL have parameter MEM_WORDS, default 1024, memory size in 32-bit words.
REQ-002 SHALL have parameter ADDR_WIDTH, default 22, byte-address width per requester.
REQ-003 SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-004 SHALL have port resetn  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port req_valid  input  3  request per requester: bit0 MPU table loader, bit1 data access, bit2 instruction fetch.
REQ-006 SHALL have port req_addr  input  3*ADDR_WIDTH  byte address per requester; requester n uses slice n.
REQ-007 SHALL have port req_wdata  input  96  write data per requester; 32 bits each.
REQ-008 SHALL have port req_wstrb  input  12  byte strobes per requester; 4 bits each; all zero means read.
REQ-009 SHALL have port req_ready  output  3  one-cycle completion pulse per requester.
REQ-010 SHALL have port req_rdata  output  32  read data for the completing requester; valid while its req_ready is high.
REQ-011 SHALL have port req_err  output  1  pulses with req_ready when the address is out of range.
REQ-012 SHALL have port mem_wen  output  4  memory byte write enables.
REQ-013 SHALL have port mem_addr  output  ADDR_WIDTH  memory word address, req_addr divided by 4.
REQ-014 SHALL have port mem_wdata  output  32  memory write data.
REQ-015 SHALL have port mem_rdata  input  32  memory read data, valid one clock after mem_addr.
REQ-016 SHALL have port grant_id  output  2  index of the current owner; 3 when idle.

Function
REQ-017 SHALL implement states IDLE, ADDR, DATA and RECOVER as a registered FSM.
REQ-018 In IDLE with any req_valid bit set, SHALL select one requester, latch its addr, wdata and wstrb, set grant_id, and enter ADDR.
REQ-019 In ADDR, SHALL drive mem_addr and mem_wdata and drive mem_wen=latched wstrb for exactly this cycle, then enter DATA.
REQ-020 In DATA, SHALL register mem_rdata into req_rdata, set the granted req_ready bit, and enter RECOVER.
REQ-021 In RECOVER, req_ready SHALL be high for this cycle only, no request SHALL be sampled, and the FSM SHALL then enter IDLE.
REQ-022 Latency SHALL be: req_ready high exactly 2 edges after the IDLE sampling edge; back-to-back throughput SHALL be 1 transaction per 4 cycles.
REQ-023 mem_wen SHALL be 0 in every state except ADDR.
REQ-024 A request with addr >= 4*MEM_WORDS SHALL keep mem_wen=0 in ADDR, return req_rdata=0 and pulse req_err with req_ready.
REQ-025 A requester deasserting valid after grant SHALL NOT abort the transaction; req_ready SHALL still pulse.
REQ-026 Requests arriving outside IDLE SHALL wait, unserviced and unacknowledged, until IDLE.
REQ-027 Word-address arithmetic SHALL truncate: mem_addr = req_addr[ADDR_WIDTH-1:2] zero-extended.
REQ-028 grant_id SHALL hold its value from ADDR through RECOVER and SHALL return to 3 in IDLE.

Reset
REQ-029 On resetn low, the FSM SHALL go to IDLE immediately, regardless of the clock.
REQ-030 On resetn low: req_ready=0, req_err=0, req_rdata=0, mem_wen=0, mem_addr=0, mem_wdata=0, grant_id=3.
REQ-031 An in-flight transaction SHALL be dropped by reset with no req_ready pulse; a write is suppressed if reset precedes its ADDR cycle.
REQ-032 With round-robin compiled in, reset SHALL set the last-granted pointer to 2, so requester 0 has highest priority first.

Configuration
REQ-033 Macro MEM_PORT_ARB_RR_EN defined: selection SHALL be round-robin, with search starting at (last granted + 1) mod 3; the pointer updates on each grant.
REQ-034 Macro MEM_PORT_ARB_RR_EN undefined: selection SHALL be fixed priority bit0 > bit1 > bit2, and no pointer register SHALL exist.

Verification
REQ-035 Read: only req_valid[2] set, addr 0x10, mem holds 0xDEADBEEF at word 4 -> mem_addr=4 in ADDR; req_ready[2] and req_rdata=0xDEADBEEF 2 edges later.
REQ-036 Write: req_valid[1] set, addr 0x20, wstrb 4'b0011, wdata 0x12345678 -> mem_wen=0011 for one cycle at mem_addr=8; req_ready[1] pulses; req_err=0.
REQ-037 Out of range: req_valid[1] set, addr 0x1000, wstrb 4'hF -> mem_wen stays 0; req_rdata=0; req_err and req_ready[1] pulse together.
REQ-038 Contention: all three valid held for 12 cycles -> fixed priority grants order 0,0,0; MEM_PORT_ARB_RR_EN grants order 0,1,2.
REQ-039 Reset mid-transaction: resetn low during DATA -> outputs reach reset values before the next edge; no req_ready; grant_id=3.
REQ-040 Early drop: req_valid[0] deasserted in ADDR cycle -> req_ready[0] still pulses; the next grant occurs only after RECOVER.

Source files
------------

// File: rtl/mem_port_arb.sv
// mem_port_arb -- three-requester arbiter in front of a single-ported
// synchronous memory.
//
// Requesters: bit0 MPU table loader, bit1 data access, bit2 instruction fetch.
// Each transaction walks IDLE -> ADDR -> DATA -> RECOVER, so a grant costs
// four cycles.
//
// Ports
//   clk, resetn       single clock, asynchronous active-low reset
//   req_valid[3]      request per requester
//   req_addr          byte address per requester, slice n = requester n
//   req_wdata         32-bit write data per requester
//   req_wstrb         4-bit byte strobes per requester, all zero = read
//   req_ready[3]      one-cycle completion pulse (high in RECOVER)
//   req_rdata         read data, valid while req_ready is high
//   req_err           out-of-range flag, pulses with req_ready
//   mem_wen           byte write enables, nonzero only in ADDR
//   mem_addr          word address (byte address >> 2)
//   mem_wdata         write data
//   mem_rdata         memory read data, one cycle after mem_addr
//   grant_id          current owner, 3 when idle
//
// Build option
//   MEM_PORT_ARB_RR_EN  round-robin selection; default is fixed priority
//                       bit0 > bit1 > bit2 with no pointer register.

// Per-requester address decode: word address and range check.
module mem_port_arb_lane #(
  parameter int MEM_WORDS  = 1024,
  parameter int ADDR_WIDTH = 22
) (
  input  logic [ADDR_WIDTH-1:0] addr,
  output logic [ADDR_WIDTH-1:0] word_addr,
  output logic                  oor
);
  // Compare in 64 bits so a memory larger than the address space never wraps.
  localparam logic [63:0] LIMIT = 64'(MEM_WORDS) << 2;

  assign word_addr = {2'b00, addr[ADDR_WIDTH-1:2]};
  assign oor       = ({{(64-ADDR_WIDTH){1'b0}}, addr} >= LIMIT);
endmodule

module mem_port_arb #(
  parameter int MEM_WORDS  = 1024,
  parameter int ADDR_WIDTH = 22
) (
  input  logic                    clk,
  input  logic                    resetn,
  input  logic [2:0]              req_valid,
  input  logic [3*ADDR_WIDTH-1:0] req_addr,
  input  logic [95:0]             req_wdata,
  input  logic [11:0]             req_wstrb,
  output logic [2:0]              req_ready,
  output logic [31:0]             req_rdata,
  output logic                    req_err,
  output logic [3:0]              mem_wen,
  output logic [ADDR_WIDTH-1:0]   mem_addr,
  output logic [31:0]             mem_wdata,
  input  logic [31:0]             mem_rdata,
  output logic [1:0]              grant_id
);
  typedef enum logic [1:0] {IDLE, ADDR, DATA, RECOVER} state_t;

  state_t state, state_d;

  logic [2:0][ADDR_WIDTH-1:0] lane_waddr;
  logic [2:0]                 lane_oor;
  logic [2:0][31:0]           lane_wdata;
  logic [2:0][3:0]            lane_wstrb;

  logic [3:0] wstrb_q;
  logic       oor_q;
  logic [1:0] sel;

  for (genvar g = 0; g < 3; g++) begin : g_lane
    mem_port_arb_lane #(
      .MEM_WORDS (MEM_WORDS),
      .ADDR_WIDTH(ADDR_WIDTH)
    ) u_lane (
      .addr     (req_addr[g*ADDR_WIDTH +: ADDR_WIDTH]),
      .word_addr(lane_waddr[g]),
      .oor      (lane_oor[g])
    );
    assign lane_wdata[g] = req_wdata[g*32 +: 32];
    assign lane_wstrb[g] = req_wstrb[g*4 +: 4];
  end

`ifdef MEM_PORT_ARB_RR_EN
  logic [1:0] last_q;
  logic [1:0] cand;
  logic       found;

  function automatic logic [1:0] nxt(input logic [1:0] p);
    return (p == 2'd2) ? 2'd0 : p + 2'd1;
  endfunction

  // Walk the three requesters starting just after the last winner.
  always_comb begin
    sel   = 2'd0;
    found = 1'b0;
    cand  = nxt(last_q);
    for (int k = 0; k < 3; k++) begin
      if (!found && req_valid[cand]) begin
        sel   = cand;
        found = 1'b1;
      end
      cand = nxt(cand);
    end
  end

  // Reset to 2 so requester 0 wins the first contended grant.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn)                        last_q <= 2'd2;
    else if (state == IDLE && |req_valid) last_q <= sel;
  end
`else
  always_comb begin
    sel = 2'd2;
    if (req_valid[0])      sel = 2'd0;
    else if (req_valid[1]) sel = 2'd1;
  end
`endif

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) state <= IDLE;
    else         state <= state_d;
  end

  // Requests are only sampled in IDLE; everything after is a fixed walk.
  always_comb begin
    state_d = state;
    case (state)
      IDLE:    if (|req_valid) state_d = ADDR;
      ADDR:    state_d = DATA;
      DATA:    state_d = RECOVER;
      RECOVER: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      grant_id  <= 2'd3;
      mem_addr  <= '0;
      mem_wdata <= '0;
      wstrb_q   <= '0;
      oor_q     <= 1'b0;
      req_ready <= '0;
      req_err   <= 1'b0;
      req_rdata <= '0;
    end else begin
      req_ready <= '0;
      req_err   <= 1'b0;
      case (state)
        IDLE: if (|req_valid) begin
          grant_id  <= sel;
          mem_addr  <= lane_waddr[sel];
          mem_wdata <= lane_wdata[sel];
          wstrb_q   <= lane_wstrb[sel];
          oor_q     <= lane_oor[sel];
        end
        DATA: begin
          req_ready <= 3'b001 << grant_id;
          req_err   <= oor_q;
          req_rdata <= oor_q ? 32'd0 : mem_rdata;
        end
        RECOVER: grant_id <= 2'd3;
        default: ;
      endcase
    end
  end

  // Write strobes exist only during ADDR, and never for an out-of-range access.
  assign mem_wen = (state == ADDR && !oor_q) ? wstrb_q : 4'd0;
endmodule

// File: tb/tb_mem_port_arb.sv
module tb_mem_port_arb;
  localparam int AW = 22;

  logic          clk = 1'b0;
  logic          resetn;
  logic [2:0]    req_valid;
  logic [3*AW-1:0] req_addr;
  logic [95:0]   req_wdata;
  logic [11:0]   req_wstrb;
  logic [2:0]    req_ready;
  logic [31:0]   req_rdata;
  logic          req_err;
  logic [3:0]    mem_wen;
  logic [AW-1:0] mem_addr;
  logic [31:0]   mem_wdata;
  logic [31:0]   mem_rdata;
  logic [1:0]    grant_id;

  int errors = 0;
  int checks = 0;

  logic [31:0] mem [0:1023];
  logic [1:0]  exp_g [3];

  always #5 clk = ~clk;

  mem_port_arb #(.MEM_WORDS(1024), .ADDR_WIDTH(AW)) dut (
    .clk(clk), .resetn(resetn), .req_valid(req_valid), .req_addr(req_addr),
    .req_wdata(req_wdata), .req_wstrb(req_wstrb), .req_ready(req_ready),
    .req_rdata(req_rdata), .req_err(req_err), .mem_wen(mem_wen),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
    .grant_id(grant_id)
  );

  // Synchronous memory model: one-cycle read latency, byte writes.
  always @(posedge clk) begin
    if (!resetn) begin
      mem[4]  <= 32'hDEADBEEF;
      mem[8]  <= 32'hAABBCCDD;
      mem[16] <= 32'hCAFEF00D;
    end else if (mem_addr < AW'(1024)) begin
      for (int b = 0; b < 4; b++)
        if (mem_wen[b]) mem[mem_addr[9:0]][8*b +: 8] <= mem_wdata[8*b +: 8];
    end
    mem_rdata <= (mem_addr < AW'(1024)) ? mem[mem_addr[9:0]] : 32'hBAD0BAD0;
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int n, input logic [AW-1:0] a, input logic [31:0] d,
                         input logic [3:0] s);
    req_addr[n*AW +: AW] = a;
    req_wdata[n*32 +: 32] = d;
    req_wstrb[n*4 +: 4] = s;
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_ready"}, 64'(req_ready), 64'd0);
    chk({tag, "_err"},   64'(req_err),   64'd0);
    chk({tag, "_rdata"}, 64'(req_rdata), 64'd0);
    chk({tag, "_wen"},   64'(mem_wen),   64'd0);
    chk({tag, "_maddr"}, 64'(mem_addr),  64'd0);
    chk({tag, "_wdata"}, 64'(mem_wdata), 64'd0);
    chk({tag, "_gnt"},   64'(grant_id),  64'd3);
  endtask

  initial begin
`ifdef MEM_PORT_ARB_RR_EN
    exp_g = '{2'd0, 2'd1, 2'd2};
`else
    exp_g = '{2'd0, 2'd0, 2'd0};
`endif
    resetn = 1'b0; req_valid = '0; req_addr = '0; req_wdata = '0; req_wstrb = '0;
    repeat (2) @(posedge clk);
    #1;
    chk_reset_vals("rst");
    resetn = 1'b1;
    tick();

    // Read from instruction fetch, word 4.
    set_req(2, 22'h10, 32'h0, 4'h0);
    req_valid = 3'b100;
    tick();
    chk("rd_gnt", 64'(grant_id), 64'd2);
    chk("rd_maddr", 64'(mem_addr), 64'd4);
    chk("rd_wen", 64'(mem_wen), 64'd0);
    req_valid = '0;
    tick();
    chk("rd_ready_data", 64'(req_ready), 64'd0);
    tick();
    chk("rd_ready", 64'(req_ready), 64'b100);
    chk("rd_rdata", 64'(req_rdata), 64'hDEADBEEF);
    chk("rd_err", 64'(req_err), 64'd0);
    tick();
    chk("rd_ready_off", 64'(req_ready), 64'd0);
    chk("rd_gnt_idle", 64'(grant_id), 64'd3);

    // Partial write from data port, word 8.
    set_req(1, 22'h20, 32'h12345678, 4'b0011);
    req_valid = 3'b010;
    tick();
    chk("wr_gnt", 64'(grant_id), 64'd1);
    chk("wr_wen", 64'(mem_wen), 64'b0011);
    chk("wr_maddr", 64'(mem_addr), 64'd8);
    chk("wr_wdata", 64'(mem_wdata), 64'h12345678);
    req_valid = '0;
    tick();
    chk("wr_wen_off", 64'(mem_wen), 64'd0);
    tick();
    chk("wr_ready", 64'(req_ready), 64'b010);
    chk("wr_err", 64'(req_err), 64'd0);
    chk("wr_mem", 64'(mem[8]), 64'hAABB5678);
    tick();

    // Out of range: first address past the end.
    set_req(1, 22'h1000, 32'hFFFFFFFF, 4'hF);
    req_valid = 3'b010;
    tick();
    chk("oor_wen", 64'(mem_wen), 64'd0);
    chk("oor_gnt", 64'(grant_id), 64'd1);
    req_valid = '0;
    tick();
    tick();
    chk("oor_ready", 64'(req_ready), 64'b010);
    chk("oor_err", 64'(req_err), 64'd1);
    chk("oor_rdata", 64'(req_rdata), 64'd0);
    tick();
    chk("oor_err_off", 64'(req_err), 64'd0);

    // Reset while in DATA.
    set_req(0, 22'h30, 32'h0, 4'h0);
    req_valid = 3'b001;
    tick();
    tick();
    #2;
    resetn = 1'b0;
    #1;
    chk_reset_vals("midrst");
    req_valid = '0;
    tick();
    resetn = 1'b1;
    chk("midrst_ready1", 64'(req_ready), 64'd0);
    tick();
    chk("midrst_ready2", 64'(req_ready), 64'd0);
    chk("midrst_gnt", 64'(grant_id), 64'd3);

    // Contention: all three held for 12 cycles.
    set_req(0, 22'h10, 32'h0, 4'h0);
    set_req(1, 22'h10, 32'h0, 4'h0);
    set_req(2, 22'h10, 32'h0, 4'h0);
    req_valid = 3'b111;
    for (int t = 0; t < 3; t++) begin
      tick();
      chk($sformatf("ct_gnt%0d", t), 64'(grant_id), 64'(exp_g[t]));
      tick();
      tick();
      chk($sformatf("ct_ready%0d", t), 64'(req_ready), 64'(3'b001 << exp_g[t]));
      chk($sformatf("ct_hold%0d", t), 64'(grant_id), 64'(exp_g[t]));
      tick();
      chk($sformatf("ct_idle%0d", t), 64'(grant_id), 64'd3);
    end
    req_valid = '0;
    tick();
    tick();
    tick();
    tick();

    // Early drop: requester 0 lets go in ADDR; requester 2 waits.
    set_req(0, 22'h40, 32'h0, 4'h0);
    set_req(2, 22'h10, 32'h0, 4'h0);
    req_valid = 3'b101;
    tick();
    chk("ed_gnt", 64'(grant_id), 64'd0);
    req_valid = 3'b100;
    tick();
    chk("ed_gnt_data", 64'(grant_id), 64'd0);
    tick();
    chk("ed_ready", 64'(req_ready), 64'b001);
    chk("ed_rdata", 64'(req_rdata), 64'hCAFEF00D);
    tick();
    chk("ed_idle", 64'(grant_id), 64'd3);
    chk("ed_ready_off", 64'(req_ready), 64'd0);
    tick();
    chk("ed_next_gnt", 64'(grant_id), 64'd2);
    req_valid = '0;
    tick();
    tick();
    chk("ed_next_ready", 64'(req_ready), 64'b100);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
